// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start 0, DATA_W bits LSB first, optional odd parity (SERIAL_TX_PARITY_EN), STOP_BITS 1s.
// First start bit appears the cycle after accept; in_ready is high in IDLE and in the final stop cycle.
module serial_frame_tx #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 1,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_bit,
   output logic              busy,
   output logic              done
);

   generate
      if (DATA_W < 1) begin : g_bad_data_w
         $error("serial_frame_tx: DATA_W must be >= 1");
      end
      if (BIT_CYCLES < 1) begin : g_bad_bit_cycles
         $error("serial_frame_tx: BIT_CYCLES must be >= 1");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
         $error("serial_frame_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int CNW = $clog2(DATA_W + 1);
   localparam logic [BCW-1:0] BAUD_LAST = BCW'(BIT_CYCLES - 1);
   localparam logic [CNW-1:0] DATA_LAST = CNW'(DATA_W - 1);
   localparam logic [CNW-1:0] STOP_LAST = CNW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [BCW-1:0]    baud_q, baud_d;
   logic [CNW-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              out_bit_q, out_bit_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
   logic              par_q, par_d;
`endif
   logic              bit_end;
   logic              last_stop;
   logic              accept;

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      done_d    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_d     = par_q;
`endif
      bit_end   = (baud_q == BAUD_LAST);
      last_stop = (state_q == S_STOP) && (bit_q == STOP_LAST) && bit_end;
      in_ready  = (state_q == S_IDLE) || last_stop;
      accept    = in_valid && in_ready;

      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + BCW'(1);
      end

      case (state_q)
         S_IDLE: state_d = S_IDLE;
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            // shift_q[0] is always the bit currently on the line
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + CNW'(1);
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + CNW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new word taken in the final stop cycle chains straight into START
      if (accept) begin
         state_d = S_START;
         shift_d = in_data;
         baud_d  = '0;
         bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
         par_d   = ~^in_data;
`endif
      end

      case (state_d)
         S_START:  out_bit_d = 1'b0;
         S_DATA:   out_bit_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: out_bit_d = par_d;
`endif
         default:  out_bit_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         out_bit_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         out_bit_q <= out_bit_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign out_bit = out_bit_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three configurations share one stimulus stream and are scored against a frame-level model.
module tb_serial_frame_tx;

   localparam int NI = 3;
`ifdef SERIAL_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FL0 = 10 + P;

   logic            clk;
   logic            reset;
   logic [7:0]      in_data;
   logic            in_valid;
   logic [NI-1:0]   rdy;
   logic [NI-1:0]   ob;
   logic [NI-1:0]   bz;
   logic [NI-1:0]   dn;

   int n_checks;
   int n_pass;

   int dw [NI];
   int bc [NI];
   int sb [NI];
   int pos [NI];
   int len [NI];
   bit done_e [NI];
   bit wave [NI][0:255];

   serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[0]), .out_bit(ob[0]), .busy(bz[0]), .done(dn[0]));

   serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .STOP_BITS(2)) u1 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy[1]), .out_bit(ob[1]), .busy(bz[1]), .done(dn[1]));

   serial_frame_tx #(.DATA_W(1), .BIT_CYCLES(2), .STOP_BITS(1)) u2 (
      .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid),
      .in_ready(rdy[2]), .out_bit(ob[2]), .busy(bz[2]), .done(dn[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Lay out the whole line waveform of one frame, each bit repeated BIT_CYCLES times
   task automatic build_frame(input int i, input logic [7:0] d);
      bit bits [$];
      int ones;
      int n;
      ones = 0;
      bits.push_back(1'b0);
      for (int b = 0; b < dw[i]; b++) begin
         bits.push_back(d[b]);
         if (d[b]) ones++;
      end
      if (P == 1) bits.push_back((ones % 2) == 0);
      for (int s = 0; s < sb[i]; s++) bits.push_back(1'b1);
      n = 0;
      foreach (bits[k]) begin
         for (int c = 0; c < bc[i]; c++) begin
            wave[i][n] = bits[k];
            n++;
         end
      end
      len[i] = n;
      pos[i] = 0;
   endtask

   task automatic model_step(input bit r, input bit v, input logic [7:0] d);
      for (int i = 0; i < NI; i++) begin
         bit ready_e;
         bit last;
         ready_e = (pos[i] < 0) || (pos[i] == len[i] - 1);
         last    = (pos[i] >= 0) && (pos[i] == len[i] - 1);
         if (r) begin
            pos[i]    = -1;
            done_e[i] = 1'b0;
         end else begin
            done_e[i] = last;
            if (v && ready_e) build_frame(i, d);
            else if (pos[i] >= 0) pos[i] = last ? -1 : pos[i] + 1;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         bit exp_out;
         bit exp_rdy;
         exp_out = (pos[i] < 0) ? 1'b1 : wave[i][pos[i]];
         exp_rdy = (pos[i] < 0) || (pos[i] == len[i] - 1);
         check_eq($sformatf("out_bit[%0d]", i), {31'b0, ob[i]}, {31'b0, exp_out});
         check_eq($sformatf("busy[%0d]", i), {31'b0, bz[i]}, {31'b0, (pos[i] >= 0)});
         check_eq($sformatf("done[%0d]", i), {31'b0, dn[i]}, {31'b0, done_e[i]});
         check_eq($sformatf("in_ready[%0d]", i), {31'b0, rdy[i]}, {31'b0, exp_rdy});
      end
   endtask

   task automatic cycle(input bit r, input bit v, input logic [7:0] d);
      reset    = r;
      in_valid = v;
      in_data  = d;
      model_step(r, v, d);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) cycle(1'b0, 1'b0, 8'($urandom));
   endtask

   // Gather n samples of u0's line, first sample being the one already present after the accept
   task automatic collect(input int n, input int v_until, input bit rand_d, input logic [7:0] d,
                          output logic [31:0] s);
      s = {31'b0, ob[0]};
      for (int j = 1; j < n; j++) begin
         cycle(1'b0, (j <= v_until), rand_d ? 8'($urandom) : d);
         s = (s << 1) | {31'b0, ob[0]};
      end
   endtask

   logic [31:0] stream;
   logic [31:0] exp_stream;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      dw = '{8, 8, 1};
      bc = '{1, 4, 2};
      sb = '{1, 2, 1};
      for (int i = 0; i < NI; i++) begin
         pos[i]    = -1;
         len[i]    = 1;
         done_e[i] = 1'b0;
      end

      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 8'h5A);
      idle(2);

      // 0xA5 after reset, in_data scrambled after accept
      cycle(1'b0, 1'b1, 8'hA5);
      collect(FL0, 0, 1'b1, 8'h00, stream);
      exp_stream = (P == 1) ? 32'b01010010111 : 32'b0101001011;
      check_eq("a5_stream", stream, exp_stream);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("a5_done", {31'b0, dn[0]}, 32'd1);
      check_eq("a5_busy", {31'b0, bz[0]}, 32'd0);
      check_eq("a5_ready", {31'b0, rdy[0]}, 32'd1);
      idle(60);

      // Back-to-back 0x01 then 0xFF with in_valid held
      cycle(1'b0, 1'b1, 8'h01);
      stream = {31'b0, ob[0]};
      for (int j = 1; j < 2 * FL0; j++) begin
         cycle(1'b0, (j <= FL0), 8'hFF);
         stream = (stream << 1) | {31'b0, ob[0]};
         if (j == FL0) begin
            check_eq("b2b_done_at_start", {31'b0, dn[0]}, 32'd1);
            check_eq("b2b_busy_held", {31'b0, bz[0]}, 32'd1);
            check_eq("b2b_second_start", {31'b0, ob[0]}, 32'd0);
         end
      end
      exp_stream = (P == 1) ? 32'b0100000000101111111111 : 32'b01000000010111111111;
      check_eq("b2b_stream", stream, exp_stream);
      idle(60);

      // Reset during data bit 3 of 0xFF, then a clean frame
      cycle(1'b0, 1'b1, 8'hFF);
      for (int j = 1; j <= 4; j++) cycle(1'b0, 1'b0, 8'hFF);
      check_eq("rst_pre_bit3", {31'b0, ob[0]}, 32'd1);
      cycle(1'b1, 1'b0, 8'h00);
      check_eq("rst_out_bit", {31'b0, ob[0]}, 32'd1);
      check_eq("rst_busy", {31'b0, bz[0]}, 32'd0);
      check_eq("rst_ready", {31'b0, rdy[0]}, 32'd1);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("rst_no_done", {31'b0, dn[0]}, 32'd0);
      cycle(1'b0, 1'b1, 8'h3C);
      collect(FL0, 0, 1'b0, 8'h3C, stream);
      exp_stream = (P == 1) ? 32'b00011110011 : 32'b0001111001;
      check_eq("post_rst_stream", stream, exp_stream);
      idle(60);

      // 0x80 with in_data toggling every cycle; u1 has two stop bits
      cycle(1'b0, 1'b1, 8'h80);
      for (int j = 0; j < 60; j++) cycle(1'b0, 1'b0, (j % 2 == 0) ? 8'h7F : 8'h80);

      for (int j = 0; j < 3000; j++) begin
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), 8'($urandom));
      end
      idle(60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
